// File: rtl/la_trigger.sv
// la_trigger: qualifies the 24-bit user probe bus before it reaches the
// logic analyzer capture block. Samples are forwarded to la_data either
// continuously (BYPASS) or only inside a trigger window. The window is opened
// by a mask/value match (optionally edge-qualified) or a software FORCE. It is
// closed after POST forwarded samples, or never when POST is 0.
//
// Optional feature macro: LA_TRIG_EDGE_EN enables the EDGE register (reg 3)
// and edge qualification of the match. When it is undefined, reg 3 is
// unmapped and the match is level-only.
//
// Ports:
//   axi_clk, axi_reset_n      clock, async active-low reset
//   axi_aw*/axi_w*            AXI-Lite write address/data (wstrb ignored)
//   axi_ar*/axi_r*            AXI-Lite read address/data
//   up_la_data [23:0]         raw probe bus
//   la_data    [23:0]         qualified probe bus (holds outside the window)
//   trig_state [1:0]          00 IDLE, 01 ARMED, 10 TRIGGERED, 11 DONE
//   trig_irq                  one-cycle pulse on ARMED -> TRIGGERED
module la_trigger #(
  parameter int pADDR_WIDTH = 15,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset_n,
  input  logic                     axi_awvalid,
  input  logic [pADDR_WIDTH-1:0]   axi_awaddr,
  output logic                     axi_awready,
  input  logic                     axi_wvalid,
  input  logic [pDATA_WIDTH-1:0]   axi_wdata,
  input  logic [pDATA_WIDTH/8-1:0] axi_wstrb,
  output logic                     axi_wready,
  input  logic                     axi_arvalid,
  input  logic [pADDR_WIDTH-1:0]   axi_araddr,
  output logic                     axi_arready,
  output logic                     axi_rvalid,
  output logic [pDATA_WIDTH-1:0]   axi_rdata,
  input  logic                     axi_rready,
  input  logic [23:0]              up_la_data,
  output logic [23:0]              la_data,
  output logic [1:0]               trig_state,
  output logic                     trig_irq
);

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_ARMED = 2'b01, ST_TRIG = 2'b10, ST_DONE = 2'b11} st_t;
  typedef enum logic [1:0] {AX_IDLE, AX_RADDR, AX_RDATA} ax_t;

  st_t         state, nxt;
  ax_t         ax;
  logic [23:0] s_in;
  logic [23:0] mask, value;
  logic [15:0] post, post_cnt, hit_cnt;
  logic        bypass, arm_p, force_p, disarm_p;
  logic        match, fire, win_end, fwd;
  logic [9:0]  ar_idx, aw_idx;
  logic [23:0] wr_data;
  logic        aw_got, w_got;
  logic [31:0] rd_word;
`ifdef LA_TRIG_EDGE_EN
  logic [23:0] s_prev;
  logic [23:0] edge_mask;
`endif

  // Address bits outside [11:2], upper data bits and byte strobes carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{axi_wstrb, axi_wdata[pDATA_WIDTH-1:24],
                         axi_awaddr[pADDR_WIDTH-1:12], axi_awaddr[1:0],
                         axi_araddr[pADDR_WIDTH-1:12], axi_araddr[1:0]};

  // ---------------- probe sampling and match ----------------
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      s_in   <= '0;
`ifdef LA_TRIG_EDGE_EN
      s_prev <= '0;
`endif
    end else begin
      s_in   <= up_la_data;
`ifdef LA_TRIG_EDGE_EN
      s_prev <= s_in;
`endif
    end
  end

`ifdef LA_TRIG_EDGE_EN
  assign match = (((s_in ^ value) & mask) == '0) &&
                 ((edge_mask == '0) || (|((s_in ^ s_prev) & edge_mask)));
`else
  assign match = (((s_in ^ value) & mask) == '0);
`endif

  // ---------------- AXI-Lite slave + register file ----------------
  always_comb begin
    rd_word = '1;
    case (ar_idx)
      10'd0:   rd_word = {29'b0, bypass, 2'b0};
      10'd1:   rd_word = {8'b0, mask};
      10'd2:   rd_word = {8'b0, value};
`ifdef LA_TRIG_EDGE_EN
      10'd3:   rd_word = {8'b0, edge_mask};
`endif
      10'd4:   rd_word = {16'b0, post};
      10'd5:   rd_word = {8'b0, hit_cnt, 6'b0, state};
      default: rd_word = '1;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      ax <= AX_IDLE;
      axi_awready <= 1'b0; axi_wready <= 1'b0; axi_arready <= 1'b0;
      axi_rvalid <= 1'b0;  axi_rdata <= '0;
      ar_idx <= '0; aw_idx <= '0; wr_data <= '0; aw_got <= 1'b0; w_got <= 1'b0;
      bypass <= 1'b1; mask <= '0; value <= '0; post <= '0;
      arm_p <= 1'b0; force_p <= 1'b0; disarm_p <= 1'b0;
`ifdef LA_TRIG_EDGE_EN
      edge_mask <= '0;
`endif
    end else begin
      axi_awready <= 1'b0; axi_wready <= 1'b0; axi_arready <= 1'b0;
      arm_p <= 1'b0; force_p <= 1'b0; disarm_p <= 1'b0;
      case (ax)
        AX_IDLE: begin
          // Commit on the edge that closes the last of the two ready pulses.
          if (aw_got && w_got && (axi_awready || axi_wready)) begin
            aw_got <= 1'b0; w_got <= 1'b0;
            case (aw_idx)
              10'd0: begin
                bypass   <= wr_data[2];
                arm_p    <= wr_data[0];
                force_p  <= wr_data[1];
                disarm_p <= wr_data[3];
              end
              10'd1: mask  <= wr_data;
              10'd2: value <= wr_data;
`ifdef LA_TRIG_EDGE_EN
              10'd3: edge_mask <= wr_data;
`endif
              10'd4: post  <= wr_data[15:0];
              default: ;
            endcase
          end else if (!aw_got && !w_got && axi_arvalid) begin
            // A read is only started with no write half-collected, so reads
            // win a same-cycle collision and one transaction is in flight.
            ar_idx <= axi_araddr[11:2];
            axi_arready <= 1'b1;
            ax <= AX_RADDR;
          end else begin
            if (!aw_got && axi_awvalid) begin
              aw_idx <= axi_awaddr[11:2]; axi_awready <= 1'b1; aw_got <= 1'b1;
            end
            if (!w_got && axi_wvalid) begin
              wr_data <= axi_wdata[23:0]; axi_wready <= 1'b1; w_got <= 1'b1;
            end
          end
        end
        AX_RADDR: begin
          axi_rvalid <= 1'b1;
          axi_rdata  <= rd_word;
          ax <= AX_RDATA;
        end
        AX_RDATA: begin
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
            ax <= AX_IDLE;
          end
        end
        default: ax <= AX_IDLE;
      endcase
    end
  end

  // ---------------- trigger FSM ----------------
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) state <= ST_IDLE;
    else              state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (disarm_p)   nxt = ST_IDLE;
    else if (arm_p) nxt = ST_ARMED;
    else begin
      case (state)
        ST_ARMED: if (fire)    nxt = ST_TRIG;
        ST_TRIG:  if (win_end) nxt = ST_DONE;
        default:  nxt = state;
      endcase
    end
  end

  always_comb begin
    trig_state = state;
    // A pending ARM/DISARM pulse suppresses the trigger for that cycle.
    fire    = (state == ST_ARMED) && (match || force_p) && !arm_p && !disarm_p;
    // post_cnt counts samples already forwarded (trigger sample = 1), so the
    // window closes without forwarding once it reaches POST.
    win_end = (state == ST_TRIG) && (post != '0) && (post_cnt == post);
    fwd     = bypass || fire || ((state == ST_TRIG) && !win_end);
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      post_cnt <= '0; hit_cnt <= '0; trig_irq <= 1'b0; la_data <= '0;
    end else begin
      trig_irq <= fire;
      if (fire && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      if (arm_p)                                          post_cnt <= '0;
      else if (fire)                                      post_cnt <= 16'd1;
      else if (state == ST_TRIG && post_cnt != 16'hFFFF)  post_cnt <= post_cnt + 16'd1;
      if (fwd) la_data <= s_in;
    end
  end

endmodule

// File: tb/tb_la_trigger.sv
// Self-checking bench for la_trigger. Register reads are scored by a monitor
// against a queue of expected words; la_data changes are scored by a second
// monitor against a queue of expected new values.
module tb_la_trigger;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        awvalid = 0, wvalid = 0, arvalid = 0, rready = 0;
  logic [14:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        awready, wready, arready, rvalid, trig_irq;
  logic [31:0] rdata;
  logic [23:0] up = '0, la_data;
  logic [1:0]  trig_state;

  la_trigger dut (
    .axi_clk(clk), .axi_reset_n(rst_n),
    .axi_awvalid(awvalid), .axi_awaddr(awaddr), .axi_awready(awready),
    .axi_wvalid(wvalid), .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wready(wready),
    .axi_arvalid(arvalid), .axi_araddr(araddr), .axi_arready(arready),
    .axi_rvalid(rvalid), .axi_rdata(rdata), .axi_rready(rready),
    .up_la_data(up), .la_data(la_data), .trig_state(trig_state), .trig_irq(trig_irq)
  );

  always #5 clk = ~clk;

  localparam logic [14:0] A_CTRL = 15'h00, A_MASK = 15'h04, A_VALUE = 15'h08,
                          A_EDGE = 15'h0C, A_POST = 15'h10, A_STAT = 15'h14;

  int checks = 0, passes = 0, irq_cnt = 0;
  logic [31:0] rd_q[$];
  string       rdn_q[$];
  logic [23:0] la_q[$];
  logic [23:0] la_last = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
  endtask

  // read-data monitor
  always @(negedge clk) begin
    string nm;
    if (rvalid && rready) begin
      if (rd_q.size() == 0) begin
        checks++;
        $display("FAIL rd_unexpected: got 0x%08h want no response", rdata);
      end else begin
        nm = rdn_q.pop_front();
        chk(nm, rdata, rd_q.pop_front());
      end
    end
  end

  // la_data change monitor
  always @(negedge clk) begin
    if (la_data !== la_last) begin
      if (la_q.size() == 0) begin
        checks++;
        $display("FAIL la_unexpected: got 0x%06h want hold at 0x%06h", la_data, la_last);
      end else chk("la_data", {8'h0, la_data}, {8'h0, la_q.pop_front()});
      la_last = la_data;
    end
  end

  always @(negedge clk) if (trig_irq === 1'b1) irq_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [14:0] a, input logic [31:0] d);
    bit awd = 0, wd = 0, awp = 0, wp = 0;
    int n = 0;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    while (!(awd && wd) && n < 50) begin
      @(posedge clk); #1; n++;
      if (awp) begin awvalid = 0; awd = 1; awp = 0; end
      if (wp)  begin wvalid = 0;  wd = 1;  wp = 0;  end
      if (awvalid && awready) awp = 1;
      if (wvalid && wready)   wp = 1;
    end
    if (!(awd && wd)) begin
      checks++;
      $display("FAIL axi_write_timeout: addr 0x%04h got no handshake want handshake", a);
      awvalid = 0; wvalid = 0;
    end
    cyc(3);
  endtask

  task automatic axi_read(input logic [14:0] a, input logic [31:0] e, input string nm);
    int n = 0;
    rd_q.push_back(e); rdn_q.push_back(nm);
    araddr = a; arvalid = 1; rready = 1;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    if (!arready) begin
      checks++;
      $display("FAIL %s_ar_timeout: got no arready want arready", nm);
      arvalid = 0; rready = 0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rvalid) begin
      checks++;
      $display("FAIL %s_r_timeout: got no rvalid want rvalid", nm);
      rready = 0;
      return;
    end
    @(posedge clk); #1;
    rready = 0;
    cyc(1);
  endtask

  initial begin
    logic [23:0] seq [10];
    int ib;
    seq = '{24'h000000, 24'h00005A, 24'h000101, 24'h000202, 24'h000303,
            24'h000404, 24'h000505, 24'h000606, 24'h000707, 24'h000808};

    // reset state
    #2 rst_n = 0;
    cyc(3);
    chk("rst_la_data", {8'h0, la_data}, 32'h0);
    chk("rst_state", {30'h0, trig_state}, 32'h0);
    chk("rst_axi_out", {27'h0, trig_irq, awready, wready, arready, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1;
    cyc(2);

    // bypass after reset
    la_q.push_back(24'h123456);
    up = 24'h123456;
    cyc(4);
    chk("bypass_state", {30'h0, trig_state}, 32'h0);
    axi_read(A_CTRL, 32'h4, "ctrl_reset");

    // mask/value window, POST=4
    axi_write(A_CTRL, 32'h0);
    axi_write(A_MASK, 32'hFF);
    axi_write(A_VALUE, 32'h5A);
    axi_write(A_POST, 32'h4);
    axi_write(A_CTRL, 32'h1);
    axi_read(A_STAT, 32'h0000_0001, "stat_armed");
    ib = irq_cnt;
    la_q.push_back(24'h00005A); la_q.push_back(24'h000101);
    la_q.push_back(24'h000202); la_q.push_back(24'h000303);
    foreach (seq[i]) begin up = seq[i]; cyc(1); end
    cyc(5);
    chk("irq_pulses", irq_cnt - ib, 32'd1);
    axi_read(A_STAT, 32'h0000_0103, "stat_win_done");

    // edge qualifier (or level-only when the edge feature is absent)
    up = 24'h000001;
    cyc(3);
`ifndef LA_TRIG_EDGE_EN
    la_q.push_back(24'h000001);
`endif
    axi_write(A_EDGE, 32'h1);
    axi_write(A_MASK, 32'h0);
    axi_write(A_POST, 32'h2);
    axi_write(A_CTRL, 32'h1);
    cyc(5);
`ifdef LA_TRIG_EDGE_EN
    axi_read(A_STAT, 32'h0000_0101, "stat_edge_steady");
    la_q.push_back(24'h000000);
    up = 24'h000000;
    cyc(5);
    axi_read(A_EDGE, 32'h1, "edge_reg");
`else
    axi_read(A_EDGE, 32'hFFFF_FFFF, "edge_unmapped");
`endif
    axi_read(A_STAT, 32'h0000_0203, "stat_edge_done");

    // FORCE in ARMED, then FORCE in IDLE
    axi_write(A_MASK, 32'hFF_FFFF);
    axi_write(A_VALUE, 32'hAB_CDEF);
    axi_write(A_CTRL, 32'h1);
    axi_read(A_STAT, 32'h0000_0201, "stat_force_armed");
    axi_write(A_CTRL, 32'h2);
    cyc(3);
    axi_read(A_STAT, 32'h0000_0303, "stat_forced");
    axi_write(A_CTRL, 32'h8);
    axi_read(A_STAT, 32'h0000_0300, "stat_disarm");
    axi_write(A_CTRL, 32'h2);
    axi_read(A_STAT, 32'h0000_0300, "stat_force_idle");

    // POST=0 unlimited window, then DISARM freezes la_data
    axi_write(A_EDGE, 32'h0);
    axi_write(A_MASK, 32'h0);
    axi_write(A_POST, 32'h0);
    axi_write(A_CTRL, 32'h1);
    cyc(1100);
    axi_read(A_STAT, 32'h0000_0402, "stat_unlimited");
    la_q.push_back(24'h00ABCD);
    up = 24'h00ABCD;
    cyc(5);
    axi_write(A_CTRL, 32'h8);
    up = 24'h00FFFF;
    cyc(6);
    chk("la_frozen", {8'h0, la_data}, 32'h0000_ABCD);
    axi_read(A_STAT, 32'h0000_0400, "stat_unlim_idle");

    // read/write collision: read sees the old MASK
    fork
      axi_read(A_MASK, 32'h0, "collide_read");
      axi_write(A_MASK, 32'hAA);
    join
    axi_read(A_MASK, 32'hAA, "collide_write");
    axi_read(15'h40, 32'hFFFF_FFFF, "unmapped_rd");

    // reset in the middle of an open window
    axi_write(A_MASK, 32'h0);
    la_q.push_back(24'h00FFFF);
    axi_write(A_CTRL, 32'h1);
    cyc(5);
    chk("win_open_state", {30'h0, trig_state}, 32'h2);
    la_q.push_back(24'h000000);
    rst_n = 0;
    up = 24'h0;
    #2;
    chk("midrst_la_data", {8'h0, la_data}, 32'h0);
    chk("midrst_state", {30'h0, trig_state}, 32'h0);
    chk("midrst_axi_out", {27'h0, trig_irq, awready, wready, arready, rvalid}, 32'h0);
    cyc(2);
    rst_n = 1;
    cyc(3);
    axi_read(A_CTRL, 32'h4, "ctrl_after_rst");
    axi_read(A_STAT, 32'h0, "stat_after_rst");

    cyc(5);
    chk("la_q_empty", la_q.size(), 32'd0);
    chk("rd_q_empty", rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/la_trigger.md
# la_trigger

Trigger/qualifier stage sitting directly upstream of the logic analyzer capture block. It samples the 24-bit user probe bus `up_la_data` on `axi_clk` and forwards it as `la_data` only while a capture window is open. The window is gated by a mask/value pattern match, an optional edge qualifier, a post-trigger length and a software arm/force. Configuration is done through an AXI-Lite slave in the same user-project address style as the rest of the LA path.

## Interface
Parameters:
- `pADDR_WIDTH`, 15: AXI-Lite address width.
- `pDATA_WIDTH`, 32: AXI-Lite data width.

Ports:
- `axi_clk` in 1: the single clock; all logic on its rising edge.
- `axi_reset_n` in 1: asynchronous, active-low reset.
- `axi_awvalid` in 1, `axi_awaddr` in 15, `axi_awready` out 1: write-address channel.
- `axi_wvalid` in 1, `axi_wdata` in 32, `axi_wstrb` in 4, `axi_wready` out 1: write-data channel.
  - `axi_wstrb` is ignored; full-word writes only.
- `axi_arvalid` in 1, `axi_araddr` in 15, `axi_arready` out 1: read-address channel.
- `axi_rvalid` out 1, `axi_rdata` out 32, `axi_rready` in 1: read-data channel.
- `up_la_data` in 24: raw user probe bus.
- `la_data` out 24: qualified probe bus to the LA capture block.
- `trig_state` out 2: FSM state (00 IDLE, 01 ARMED, 10 TRIGGERED, 11 DONE).
- `trig_irq` out 1: one-cycle pulse on ARMED→TRIGGERED.

## Operation
Register map is decoded on `addr[11:2]`. Unmapped reads return 0xFFFFFFFF; unmapped writes are dropped.
- 0 CTRL
  - bit0 ARM: write-1 pulse.
  - bit1 FORCE: write-1 pulse.
  - bit2 BYPASS: R/W, reset 1.
  - bit3 DISARM: write-1 pulse.
  - Reads return {29'b0, BYPASS, 2'b0}.
- 1 MASK [23:0], reset 0.
- 2 VALUE [23:0], reset 0.
- 3 EDGE [23:0], reset 0.
- 4 POST [15:0], reset 0. POST=0 means an unlimited window.
- 5 STATUS (read-only): {8'b0, hit_cnt[15:0], 6'b0, trig_state}.
  - hit_cnt saturates at 0xFFFF and is cleared only by reset.

Datapath:
- Sampling: `s_in <= up_la_data` and `s_prev <= s_in` every cycle.
- match = ((s_in ^ VALUE) & MASK) == 0, AND (EDGE == 0 OR |((s_in ^ s_prev) & EDGE)).
- MASK = 0 gives an always-true level match.

FSM:
- IDLE: ARM → ARMED.
- ARMED: match or FORCE → TRIGGERED. Load post counter with 1; increment hit_cnt; pulse `trig_irq`.
- TRIGGERED: post counter increments each cycle. When counter == POST and POST≠0 → DONE.
- DONE: ARM → ARMED.
- ARM in any state → ARMED and clears the post counter.
- DISARM in any state → IDLE.
- Simultaneous ARM and DISARM in one write: DISARM wins.
- Write of ARM in the same cycle as a match in ARMED: ARM wins, and the match is ignored for that cycle.
- FORCE outside ARMED is ignored.

`la_data` update rule:
- BYPASS=1: `la_data <= s_in` every cycle, regardless of FSM. The FSM still runs.
- BYPASS=0: `la_data <= s_in` when state==TRIGGERED, or state==ARMED with (match | FORCE). Otherwise `la_data` holds its last value, so the downstream LA sees no change.

AXI-Lite slave (single outstanding transaction; read has priority when arvalid and awvalid arrive in the same cycle):
- Read: `axi_arready` pulses 1 cycle after `axi_arvalid` is sampled in idle. `axi_rvalid`/`axi_rdata` assert the following cycle and hold until `axi_rready`. `axi_rdata` returns to 0 after the handshake.
- Write: `axi_awready` pulses when awvalid is seen. `axi_wready` pulses when wvalid is seen; same cycle if both are valid. The register update and any CTRL pulse take effect in the cycle after wready.

## Timing
- Reset values: all AXI outputs 0, `la_data` 0, `trig_state` 00, `trig_irq` 0, hit_cnt 0.
- Latency `up_la_data` → `la_data` is 2 cycles in both bypass and window modes. The triggering sample itself is forwarded.
- Window length is exactly POST cycles of forwarded samples, counting the triggering sample.
- `trig_state` reads TRIGGERED 1 cycle after the matching `s_in`. `trig_irq` is high in that same cycle.
- Reset mid-window returns everything to reset values immediately (asynchronous); no partial window resumes.
- The post counter is 16-bit. POST=0xFFFF yields 65535 forwarded cycles with no wrap.

## Configuration
- `LA_TRIG_EDGE_EN` defined: the EDGE register and edge qualification are present as described.
- `LA_TRIG_EDGE_EN` undefined:
  - Register 3 reads 0xFFFFFFFF and writes to it are dropped.
  - match is level-only: ((s_in ^ VALUE) & MASK) == 0.
  - `s_prev` is removed.

## Test plan
- After reset, BYPASS=1: drive up_la_data=0x123456 → la_data=0x123456 two cycles later; trig_state=00; read CTRL → 0x4.
- BYPASS=0, MASK=0xFF, VALUE=0x5A, POST=4, ARM; drive 0x00 then 0x00005A then ramp → trig_irq pulses once, la_data shows 0x5A then the next 3 samples, then holds; trig_state=11; STATUS hit_cnt=1.
- EDGE=0x1, MASK=0, ARM; hold bit0=1 steady → no trigger; toggle bit0 → trigger. Without `LA_TRIG_EDGE_EN`: trigger on the first cycle after ARM, and reg 3 reads 0xFFFFFFFF.
- ARMED, write FORCE → TRIGGERED; FORCE issued while IDLE → state remains 00, hit_cnt unchanged.
- POST=0 → window stays open for ≥1000 cycles; DISARM → IDLE and la_data freezes.
- Simultaneous arvalid/awvalid → read completes first, then write; unmapped read 0x40 → 0xFFFFFFFF; reset asserted mid-window → all outputs 0.
